// File: rtl/bc_io_unit.sv
// Basic Computer device-side I/O unit.
// Input path: device bytes -> FIFO -> INPR/FGI, which the computer polls.
// Output path: OUT writes -> OUTR -> valid/ready handshake to the device.
// irq is raised when interrupts are enabled and either flag is set.
//
// Handshakes (valid/ready on both device channels): a byte moves on a rising
// clock edge where valid and ready are both high. The producer holds valid and
// data stable until that edge. Ready may be high before valid appears, and
// ready never depends on valid in the same cycle.
module bc_io_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   // input device side
   input  logic [7:0]    dev_in_data,
   input  logic          dev_in_valid,
   output logic          dev_in_ready,
   // computer input side
   input  logic          inp_ack,
   output logic          FGI,
   output logic [7:0]    INPR,
   // computer output side
   input  logic          out_load,
   input  logic [7:0]    out_data,
   output logic          FGO,
   // output device side
   output logic [7:0]    dev_out_data,
   output logic          dev_out_valid,
   input  logic          dev_out_ready,
   // interrupt and status
   input  logic          IEN,
   output logic          irq,
   output logic [AW:0]   in_count,
   output logic          out_overrun,
   // output FSM state, exposed for observation
   output logic          dbg_state_o
);

   localparam logic [0:0]  ST_IDLE  = 1'b0;
   localparam logic [0:0]  ST_SEND  = 1'b1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // FIFO storage and bookkeeping
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // INPR/FGI stage
   logic          fgi_q, fgi_d;
   logic [7:0]    inpr_q, inpr_d;

   // output channel
   logic [0:0]    state_q, state_d;
   logic [7:0]    outr_q, outr_d;
   logic          ovr_q, ovr_d;

   logic          push;
   logic          load;

   // Ready comes only from registered occupancy; no bypass when full.
   assign dev_in_ready = (count_q != FULL_CNT);
   assign push         = dev_in_valid & dev_in_ready;
   // A load is held off while the computer is acknowledging, so FGI stays
   // low for at least one cycle between successive bytes.
   assign load         = ~fgi_q & (count_q != '0) & ~inp_ack;

   // FIFO pointers and occupancy
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, load})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // INPR/FGI: load from FIFO head when the flag is clear, clear on ack
   always_comb begin
      fgi_d  = fgi_q;
      inpr_d = inpr_q;
      if (load) begin
         fgi_d  = 1'b1;
         inpr_d = mem_q[rd_ptr_q];
      end else if (inp_ack && fgi_q) begin
         fgi_d  = 1'b0;
      end
   end

   // Output FSM: IDLE accepts an OUT byte, SEND holds it until the device takes it
   always_comb begin
      state_d = state_q;
      outr_d  = outr_q;
      ovr_d   = ovr_q;
      case (state_q)
         ST_IDLE: begin
            if (out_load) begin
               outr_d  = out_data;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // An OUT arriving while the byte is still pending is dropped,
            // including on the handshake edge itself.
            if (out_load) ovr_d = 1'b1;
            if (dev_out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FIFO data array; contents need no reset since occupancy gates reads
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= dev_in_data;
   end

   // All control state, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fgi_q    <= 1'b0;
         inpr_q   <= 8'h00;
         state_q  <= ST_IDLE;
         outr_q   <= 8'h00;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         fgi_q    <= fgi_d;
         inpr_q   <= inpr_d;
         state_q  <= state_d;
         outr_q   <= outr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign FGI           = fgi_q;
   assign INPR          = inpr_q;
   assign FGO           = (state_q == ST_IDLE);
   assign dev_out_valid = (state_q == ST_SEND);
   assign dev_out_data  = outr_q;
   assign irq           = IEN & (fgi_q | FGO);
   assign in_count      = count_q;
   assign out_overrun   = ovr_q;
   assign dbg_state_o   = state_q[0];

endmodule

// File: tb/tb_bc_io_unit.sv
// Directed table-driven bench for bc_io_unit.
module tb_bc_io_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] dev_in_data;
   logic       dev_in_valid;
   logic       dev_in_ready;
   logic       inp_ack;
   logic       FGI;
   logic [7:0] INPR;
   logic       out_load;
   logic [7:0] out_data;
   logic       FGO;
   logic [7:0] dev_out_data;
   logic       dev_out_valid;
   logic       dev_out_ready;
   logic       IEN;
   logic       irq;
   logic [2:0] in_count;
   logic       out_overrun;
   logic       dbg_state_o;

   int checks = 0;
   int errors = 0;

   // clock / reset block
   always #5 clk = ~clk;

   bc_io_unit #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .reset(reset),
      .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
      .inp_ack(inp_ack), .FGI(FGI), .INPR(INPR),
      .out_load(out_load), .out_data(out_data), .FGO(FGO),
      .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
      .IEN(IEN), .irq(irq), .in_count(in_count), .out_overrun(out_overrun),
      .dbg_state_o(dbg_state_o)
   );

   typedef struct {
      logic [7:0] din;  logic vin; logic ack; logic ld; logic [7:0] od; logic rdy; logic ien;
      logic e_rdy; logic e_fgi; logic [7:0] e_inpr; logic e_fgo; logic e_vout;
      logic [7:0] e_dout; logic e_irq; logic [2:0] e_cnt; logic e_ovr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(
      input logic [7:0] din, input logic vin, input logic ack, input logic ld,
      input logic [7:0] od, input logic rdy, input logic ien,
      input logic e_rdy, input logic e_fgi, input logic [7:0] e_inpr, input logic e_fgo,
      input logic e_vout, input logic [7:0] e_dout, input logic e_irq,
      input logic [2:0] e_cnt, input logic e_ovr);
      vec_t r;
      r.din = din; r.vin = vin; r.ack = ack; r.ld = ld; r.od = od; r.rdy = rdy; r.ien = ien;
      r.e_rdy = e_rdy; r.e_fgi = e_fgi; r.e_inpr = e_inpr; r.e_fgo = e_fgo; r.e_vout = e_vout;
      r.e_dout = e_dout; r.e_irq = e_irq; r.e_cnt = e_cnt; r.e_ovr = e_ovr;
      return r;
   endfunction

   // scoreboard compare
   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic e_rdy, input logic e_fgi,
                            input logic [7:0] e_inpr, input logic e_fgo, input logic e_vout,
                            input logic [7:0] e_dout, input logic e_irq,
                            input logic [2:0] e_cnt, input logic e_ovr);
      cmp({tag, ".dev_in_ready"},  {7'd0, dev_in_ready},  {7'd0, e_rdy});
      cmp({tag, ".FGI"},           {7'd0, FGI},           {7'd0, e_fgi});
      cmp({tag, ".INPR"},          INPR,                  e_inpr);
      cmp({tag, ".FGO"},           {7'd0, FGO},           {7'd0, e_fgo});
      cmp({tag, ".dev_out_valid"}, {7'd0, dev_out_valid}, {7'd0, e_vout});
      cmp({tag, ".dev_out_data"},  dev_out_data,          e_dout);
      cmp({tag, ".irq"},           {7'd0, irq},           {7'd0, e_irq});
      cmp({tag, ".in_count"},      {5'd0, in_count},      {5'd0, e_cnt});
      cmp({tag, ".out_overrun"},   {7'd0, out_overrun},   {7'd0, e_ovr});
   endtask

   // driver: apply one cycle of inputs at the falling edge
   task automatic drive(input logic [7:0] din, input logic vin, input logic ack, input logic ld,
                        input logic [7:0] od, input logic rdy, input logic ien);
      @(negedge clk);
      dev_in_data = din; dev_in_valid = vin; inp_ack = ack;
      out_load = ld; out_data = od; dev_out_ready = rdy; IEN = ien;
   endtask

   task automatic step(input logic [7:0] din, input logic vin, input logic ack, input logic ld,
                       input logic [7:0] od, input logic rdy, input logic ien);
      drive(din, vin, ack, ld, od, rdy, ien);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      dev_in_data = 8'h00; dev_in_valid = 1'b0; inp_ack = 1'b0;
      out_load = 1'b0; out_data = 8'h00; dev_out_ready = 1'b0; IEN = 1'b1;

      // Table rows: inputs held for one edge, expectations are the state after it.
      //           din  vin ack ld od  rdy ien   rdy fgi inpr  fgo vo dout  irq cnt ovr
      vecs.push_back(v(8'h41,1,0,0,8'h00,0,1, 1,0,8'h00,1,0,8'h00,1,3'd1,0)); // push, not yet visible
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h41,1,0,8'h00,1,3'd0,0)); // load one edge later
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h41,1,0,8'h00,1,3'd0,0)); // ack clears FGI
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,0,8'h41,1,0,8'h00,1,3'd0,0));
      vecs.push_back(v(8'h01,1,0,0,8'h00,0,1, 1,0,8'h41,1,0,8'h00,1,3'd1,0));
      vecs.push_back(v(8'h02,1,0,0,8'h00,0,1, 1,1,8'h01,1,0,8'h00,1,3'd1,0)); // load 01 + push 02
      vecs.push_back(v(8'h03,1,0,0,8'h00,0,1, 1,1,8'h01,1,0,8'h00,1,3'd2,0));
      vecs.push_back(v(8'h04,1,0,0,8'h00,0,1, 1,1,8'h01,1,0,8'h00,1,3'd3,0));
      vecs.push_back(v(8'h05,1,0,0,8'h00,0,1, 0,1,8'h01,1,0,8'h00,1,3'd4,0)); // full
      vecs.push_back(v(8'h06,1,0,0,8'h00,0,1, 0,1,8'h01,1,0,8'h00,1,3'd4,0)); // refused
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 0,0,8'h01,1,0,8'h00,1,3'd4,0));
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h02,1,0,8'h00,1,3'd3,0));
      vecs.push_back(v(8'h07,1,1,0,8'h00,0,1, 0,0,8'h02,1,0,8'h00,1,3'd4,0)); // ack+push, holding 3
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h03,1,0,8'h00,1,3'd3,0));
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h03,1,0,8'h00,1,3'd3,0));
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h04,1,0,8'h00,1,3'd2,0));
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h04,1,0,8'h00,1,3'd2,0));
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h05,1,0,8'h00,1,3'd1,0));
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h05,1,0,8'h00,1,3'd1,0));
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h05,1,0,8'h00,1,3'd1,0)); // ack at FGI=0 blocks load
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h07,1,0,8'h00,1,3'd0,0));
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,0, 1,0,8'h07,1,0,8'h00,0,3'd0,0)); // IEN=0 masks irq
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,0,8'h07,1,0,8'h00,1,3'd0,0)); // irq via FGO
      vecs.push_back(v(8'h00,0,0,1,8'hA5,0,1, 1,0,8'h07,0,1,8'hA5,0,3'd0,0)); // OUT -> SEND
      vecs.push_back(v(8'h99,1,0,0,8'h00,0,1, 1,0,8'h07,0,1,8'hA5,0,3'd1,0));
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,1,8'h99,0,1,8'hA5,1,3'd0,0)); // irq via FGI
      vecs.push_back(v(8'h00,0,1,0,8'h00,0,1, 1,0,8'h99,0,1,8'hA5,0,3'd0,0));
      vecs.push_back(v(8'h00,0,0,0,8'h00,0,1, 1,0,8'h99,0,1,8'hA5,0,3'd0,0)); // A5 held 5 cycles
      vecs.push_back(v(8'h00,0,0,1,8'h3C,0,1, 1,0,8'h99,0,1,8'hA5,0,3'd0,1)); // overrun, A5 kept
      vecs.push_back(v(8'h00,0,0,0,8'h00,1,1, 1,0,8'h99,1,0,8'hA5,1,3'd0,1)); // handshake
      vecs.push_back(v(8'h00,0,0,1,8'h5A,1,1, 1,0,8'h99,0,1,8'h5A,0,3'd0,1)); // ready high on entry
      vecs.push_back(v(8'h00,0,0,0,8'h00,1,1, 1,0,8'h99,1,0,8'h5A,1,3'd0,1)); // 1-cycle SEND

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check_all("reset", 1, 0, 8'h00, 1, 0, 8'h00, 1, 3'd0, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].din, vecs[i].vin, vecs[i].ack, vecs[i].ld, vecs[i].od, vecs[i].rdy, vecs[i].ien);
         check_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_fgi, vecs[i].e_inpr,
                   vecs[i].e_fgo, vecs[i].e_vout, vecs[i].e_dout, vecs[i].e_irq,
                   vecs[i].e_cnt, vecs[i].e_ovr);
      end

      // Reset in the middle of SEND with two bytes queued behind a full INPR
      step(8'hB1, 1, 0, 0, 8'h00, 0, 1);
      step(8'h00, 0, 0, 0, 8'h00, 0, 1);                 // B1 -> INPR
      step(8'hB2, 1, 0, 0, 8'h00, 0, 1);
      step(8'hB3, 1, 0, 0, 8'h00, 0, 1);
      step(8'h00, 0, 0, 1, 8'hC3, 0, 1);                 // SEND with C3
      check_all("pre_reset", 1, 1, 8'hB1, 0, 1, 8'hC3, 1, 3'd2, 1);
      cmp("pre_reset.dbg_state", {7'd0, dbg_state_o}, 8'h01);
      drive(8'h00, 0, 0, 0, 8'h00, 0, 1);
      #2 reset = 1'b1;
      #1;
      check_all("async_reset", 1, 0, 8'h00, 1, 0, 8'h00, 1, 3'd0, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(8'h00, 0, 0, 0, 8'h00, 0, 1);
         check_all($sformatf("post_reset%0d", i), 1, 0, 8'h00, 1, 0, 8'h00, 1, 3'd0, 0);
      end

      // OUT on the very edge of the handshake is dropped and flagged
      step(8'h00, 0, 0, 1, 8'h11, 0, 1);
      cmp("hs.enter_data", dev_out_data, 8'h11);
      step(8'h00, 0, 0, 1, 8'h22, 1, 1);
      check_all("hs_same_edge", 1, 0, 8'h00, 1, 0, 8'h11, 1, 3'd0, 1);
      step(8'h00, 0, 0, 0, 8'h00, 0, 1);
      check_all("hs_after", 1, 0, 8'h00, 1, 0, 8'h11, 1, 3'd0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bc_io_unit.md
Name: bc_io_unit

Overview:
- Device-side I/O unit for the Basic Computer.
- Produces the FGI/INPR input flag and register that the computer polls, and sinks the computer's OUT writes into an OUTR/FGO output channel.
- Input side: external device bytes are buffered in a small FIFO, then presented one at a time through INPR/FGI.
- Output side: a two-state FSM drives a valid/ready handshake to the external device.
- Also generates the interrupt request from IEN, FGI and FGO.

Parameters:
- DEPTH, 4, input FIFO entries; power of 2, minimum 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- dev_in_data  input  8  byte from the external input device
- dev_in_valid  input  1  dev_in_data is valid
- dev_in_ready  output  1  FIFO can accept a byte
- inp_ack  input  1  one-cycle pulse: computer executed INP (INPR consumed)
- FGI  output  1  input flag; INPR holds an unread byte
- INPR  output  8  input register
- out_load  input  1  one-cycle pulse: computer executed OUT
- out_data  input  8  AC[7:0], sampled on out_load
- FGO  output  1  output flag; OUTR is free
- dev_out_data  output  8  OUTR contents presented to the external device
- dev_out_valid  output  1  OUTR byte pending
- dev_out_ready  input  1  external device accepts the byte
- IEN  input  1  interrupt enable from the controller
- irq  output  1  interrupt request
- in_count  output  AW+1  current FIFO occupancy, 0..DEPTH
- out_overrun  output  1  sticky: out_load was received while FGO=0

Behaviour:

Reset (asynchronous, takes effect immediately, any state, including mid-transfer):
- FIFO emptied; in_count=0; dev_in_ready=1.
- FGI=0; INPR=0x00.
- FSM goes to IDLE; FGO=1; dev_out_valid=0; dev_out_data=0x00.
- out_overrun=0.
- Any in-flight byte is discarded.

Input FIFO:
- dev_in_ready = (in_count != DEPTH), taken from registered state only.
- Push on a rising edge with dev_in_valid & dev_in_ready.
- When full, dev_in_ready=0 even if a pop occurs in the same cycle. No bypass.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave in_count unchanged.

INPR/FGI stage:
- Load condition: FGI=0, in_count>0 and inp_ack=0. On that edge, INPR <= FIFO head, pop, FGI <= 1.
- Latency: with empty FIFO and FGI=0, a byte pushed at edge t appears on INPR with FGI=1 after edge t+1.
- inp_ack while FGI=1: FGI <= 0. INPR keeps its value until the next load.
- inp_ack while FGI=0: ignored.
- The next load happens no earlier than the edge after the one that cleared FGI, so FGI is low for at least one cycle between bytes.
- INPR never changes while FGI=1.

Output FSM:
- IDLE: FGO=1, dev_out_valid=0.
  - out_load: OUTR <= out_data, go to SEND.
- SEND: FGO=0, dev_out_valid=1, dev_out_data held stable.
  - dev_out_ready high at an edge: go to IDLE, FGO=1 next cycle.
  - out_load: OUTR not modified, out_overrun <= 1.
- OUT-to-valid latency: 1 cycle.
- Minimum SEND duration: 1 cycle. Ready may already be high on entry.
- out_load in the same cycle as the SEND-to-IDLE handshake is treated as occurring in SEND: overrun is set and the byte is dropped.

Interrupt:
- irq = IEN & (FGI | FGO), combinational.
- After reset irq follows IEN, because FGO=1.

Test Plan:
- Reset, then push 0x41 → dev_in_ready=1 throughout; INPR=0x41 and FGI=1 one edge after the push; irq=1 with IEN=1; pulse inp_ack → FGI=0, INPR stays 0x41.
- Hold FGI=1 (no ack), push 0x01..0x05 → 0x01 goes to INPR, 0x02..0x05 fill the FIFO, in_count=4, dev_in_ready=0; four ack/reload cycles deliver 0x02..0x05 in order, with FGI low ≥1 cycle between bytes.
- Ack and push in the same cycle with FIFO holding 3 → no INPR update that cycle; the next byte loads on the following edge; in_count is correct.
- out_load with out_data=0xA5, dev_out_ready=0 → next cycle FGO=0, dev_out_valid=1, dev_out_data=0xA5 held 5 cycles; raise ready → FGO=1 next cycle.
- In SEND, pulse out_load with 0x3C → out_overrun=1 and dev_out_data remains 0xA5.
- Assert reset mid-SEND with FIFO holding 2 → all outputs return to reset values immediately; the in-flight bytes never appear.
